branch_predictor_table: RTL and testbench

- Branch target buffer with 2-bit saturating counters. Sits in fetch; it is the consumer/producer end of the branch-table path.
- Predicts the next PC for the fetch stage.
- Carries the prediction to execute alongside the instruction.
- Receives branch/jump resolution from the branch unit, updates its entries, and issues a flush with the corrected PC on misprediction.

---
 rtl/branch_predictor_table.sv | 219 +++++++++++++++++++++
 tb/tb_branch_predictor_table.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_table.sv
// Branch target buffer with 2-bit saturating counters, placed in fetch.
// It looks up a predicted next PC for each fetch PC and carries the
// prediction of the decoded branch into execute. Branch-unit resolutions
// update the table, and a misprediction raises a one-cycle redirect.
//
// Optional build macro: BRANCH_PREDICTOR_STATS_EN adds the counters
// stat_branches and stat_mispredicts.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   if_pc, if_valid, if_stall         fetch lookup request and hold
//   if_pred_valid/taken/target        registered lookup result
//   new_request_dec, pred_*_dec       prediction leaving decode
//   branch_ex, ex_pc, branch_taken,
//   jump_pc, njump_pc                 resolution from the branch unit
//   flush, new_pc                     registered redirect
//   stat_branches, stat_mispredicts   resolution and misprediction counts (optional)
module branch_predictor_table #(
  parameter int unsigned BTB_ENTRIES = 64,
  parameter int unsigned TAG_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  input  logic        if_valid,
  input  logic        if_stall,
  output logic        if_pred_valid,
  output logic        if_pred_taken,
  output logic [31:0] if_pred_target,
  input  logic        new_request_dec,
  input  logic        pred_taken_dec,
  input  logic [31:0] pred_target_dec,
  input  logic        branch_ex,
  input  logic [31:0] ex_pc,
  input  logic        branch_taken,
  input  logic [31:0] jump_pc,
  input  logic [31:0] njump_pc,
  output logic        flush,
  output logic [31:0] new_pc
`ifdef BRANCH_PREDICTOR_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);

  localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
  localparam int unsigned PC_W  = 32;

  // Table storage
  logic              valid_q  [BTB_ENTRIES];
  logic [TAG_W-1:0]  tag_q    [BTB_ENTRIES];
  logic [1:0]        cnt_q    [BTB_ENTRIES];
  logic [PC_W-1:0]   target_q [BTB_ENTRIES];

  // Lookup pipeline register
  logic              lk_valid_q, lk_valid_d;
  logic              lk_taken_q, lk_taken_d;
  logic [PC_W-1:0]   lk_target_q, lk_target_d;
  logic              pred_valid_q, pred_valid_d;

  // Prediction carried into execute
  logic              pred_taken_ex_q, pred_taken_ex_d;
  logic [PC_W-1:0]   pred_target_ex_q, pred_target_ex_d;

  // Redirect
  logic              flush_q, flush_d;
  logic [PC_W-1:0]   new_pc_q, new_pc_d;

  logic [IDX_W-1:0]  lk_idx_c, up_idx_c;
  logic [TAG_W-1:0]  lk_tag_c, up_tag_c;
  logic              lk_hit_c, up_hit_c;
  logic              mispredict_c;
  logic [1:0]        cnt_nx_c;
  logic              unused_pc_bits_c;

  // Address split for the lookup and update ports
  assign lk_idx_c = if_pc[IDX_W+1:2];
  assign lk_tag_c = if_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign up_idx_c = ex_pc[IDX_W+1:2];
  assign up_tag_c = ex_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign unused_pc_bits_c = ^{if_pc, ex_pc};

  assign lk_hit_c = valid_q[lk_idx_c] && (tag_q[lk_idx_c] == lk_tag_c);
  assign up_hit_c = valid_q[up_idx_c] && (tag_q[up_idx_c] == up_tag_c);

  // Wrong direction, or taken in both cases but to a different target
  assign mispredict_c = branch_ex &&
                        ((pred_taken_ex_q != branch_taken) ||
                         (pred_taken_ex_q && branch_taken && (pred_target_ex_q != jump_pc)));

  // Saturating counter next value; a taken miss allocates at weakly-taken
  always_comb begin
    cnt_nx_c = cnt_q[up_idx_c];
    if (branch_taken) begin
      if (!up_hit_c) begin
        cnt_nx_c = 2'd2;
      end else if (cnt_q[up_idx_c] != 2'd3) begin
        cnt_nx_c = cnt_q[up_idx_c] + 2'd1;
      end
    end else if (up_hit_c && (cnt_q[up_idx_c] != 2'd0)) begin
      cnt_nx_c = cnt_q[up_idx_c] - 2'd1;
    end
  end

  // Lookup, carry and redirect next-state
  always_comb begin
    lk_valid_d       = lk_valid_q;
    lk_taken_d       = lk_taken_q;
    lk_target_d      = lk_target_q;
    pred_taken_ex_d  = pred_taken_ex_q;
    pred_target_ex_d = pred_target_ex_q;
    flush_d          = mispredict_c;
    new_pc_d         = new_pc_q;

    if (!if_stall) begin
      lk_valid_d  = if_valid;
      lk_taken_d  = if_valid && lk_hit_c && cnt_q[lk_idx_c][1];
      lk_target_d = (if_valid && lk_hit_c) ? target_q[lk_idx_c] : '0;
    end

    if (new_request_dec) begin
      pred_taken_ex_d  = pred_taken_dec;
      pred_target_ex_d = pred_target_dec;
    end

    if (mispredict_c) begin
      new_pc_d = branch_taken ? jump_pc : njump_pc;
    end

    // A redirect cycle masks the visible valid; the held lookup stays intact
    pred_valid_d = lk_valid_d && !flush_d;
  end

  // Pipeline and redirect registers
  always_ff @(posedge clk) begin
    if (rst) begin
      lk_valid_q       <= 1'b0;
      lk_taken_q       <= 1'b0;
      lk_target_q      <= '0;
      pred_valid_q     <= 1'b0;
      pred_taken_ex_q  <= 1'b0;
      pred_target_ex_q <= '0;
      flush_q          <= 1'b0;
      new_pc_q         <= '0;
    end else begin
      lk_valid_q       <= lk_valid_d;
      lk_taken_q       <= lk_taken_d;
      lk_target_q      <= lk_target_d;
      pred_valid_q     <= pred_valid_d;
      pred_taken_ex_q  <= pred_taken_ex_d;
      pred_target_ex_q <= pred_target_ex_d;
      flush_q          <= flush_d;
      new_pc_q         <= new_pc_d;
    end
  end

  // Valid bits and counters; reset invalidates the whole table
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= 2'b00;
      end
    end else if (branch_ex) begin
      if (branch_taken) begin
        valid_q[up_idx_c] <= 1'b1;
        cnt_q[up_idx_c]   <= cnt_nx_c;
      end else if (up_hit_c) begin
        cnt_q[up_idx_c]   <= cnt_nx_c;
      end
    end
  end

  // Tags and targets are qualified by the valid bits, so they skip reset
  always_ff @(posedge clk) begin
    if (!rst && branch_ex && branch_taken) begin
      tag_q[up_idx_c]    <= up_tag_c;
      target_q[up_idx_c] <= jump_pc;
    end
  end

  assign if_pred_valid  = pred_valid_q;
  assign if_pred_taken  = lk_taken_q;
  assign if_pred_target = lk_target_q;
  assign flush          = flush_q;
  assign new_pc         = new_pc_q;

`ifdef BRANCH_PREDICTOR_STATS_EN
  logic [31:0] stat_br_q, stat_br_d;
  logic [31:0] stat_mp_q, stat_mp_d;

  // Saturating event counters
  always_comb begin
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    if (branch_ex && (stat_br_q != 32'hFFFF_FFFF)) begin
      stat_br_d = stat_br_q + 32'd1;
    end
    if (mispredict_c && (stat_mp_q != 32'hFFFF_FFFF)) begin
      stat_mp_d = stat_mp_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;
`endif

endmodule

// File: tb/tb_branch_predictor_table.sv
// Bench for branch_predictor_table: a reference model pushes expected
// outputs per cycle, compared after each edge, plus directed constants.
module tb_branch_predictor_table;

  logic        clk;
  logic        rst;
  logic [31:0] if_pc;
  logic        if_valid;
  logic        if_stall;
  logic        if_pred_valid;
  logic        if_pred_taken;
  logic [31:0] if_pred_target;
  logic        new_request_dec;
  logic        pred_taken_dec;
  logic [31:0] pred_target_dec;
  logic        branch_ex;
  logic [31:0] ex_pc;
  logic        branch_taken;
  logic [31:0] jump_pc;
  logic [31:0] njump_pc;
  logic        flush;
  logic [31:0] new_pc;
`ifdef BRANCH_PREDICTOR_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  branch_predictor_table #(.BTB_ENTRIES(64), .TAG_W(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .if_pc           (if_pc),
    .if_valid        (if_valid),
    .if_stall        (if_stall),
    .if_pred_valid   (if_pred_valid),
    .if_pred_taken   (if_pred_taken),
    .if_pred_target  (if_pred_target),
    .new_request_dec (new_request_dec),
    .pred_taken_dec  (pred_taken_dec),
    .pred_target_dec (pred_target_dec),
    .branch_ex       (branch_ex),
    .ex_pc           (ex_pc),
    .branch_taken    (branch_taken),
    .jump_pc         (jump_pc),
    .njump_pc        (njump_pc),
    .flush           (flush),
    .new_pc          (new_pc)
`ifdef BRANCH_PREDICTOR_STATS_EN
    ,
    .stat_branches   (stat_branches),
    .stat_mispredicts(stat_mispredicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        pv;
    logic        pt;
    logic [31:0] tgt;
    logic        fl;
    logic [31:0] npc;
    logic [31:0] sb;
    logic [31:0] sm;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state (64 entries, 8-bit tags)
  logic        m_valid [64];
  logic [7:0]  m_tag   [64];
  logic [1:0]  m_cnt   [64];
  logic [31:0] m_tgt   [64];
  logic        m_lk_v, m_lk_t, m_fl, m_ptex;
  logic [31:0] m_lk_tgt, m_npc, m_ptgtex, m_sb, m_sm;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance the model by one edge using the currently driven inputs
  task automatic model_eval(output exp_t e);
    logic [5:0] li, ui;
    logic [7:0] lt, ut;
    logic       lhit, uhit, mis;
    if (rst) begin
      for (int i = 0; i < 64; i++) begin
        m_valid[i] = 1'b0;
        m_cnt[i]   = 2'd0;
      end
      m_lk_v = 1'b0; m_lk_t = 1'b0; m_lk_tgt = 32'd0;
      m_fl = 1'b0; m_npc = 32'd0; m_ptex = 1'b0; m_ptgtex = 32'd0;
      m_sb = 32'd0; m_sm = 32'd0;
    end else begin
      li = if_pc[7:2]; lt = if_pc[15:8];
      ui = ex_pc[7:2]; ut = ex_pc[15:8];
      lhit = m_valid[li] && (m_tag[li] == lt);
      uhit = m_valid[ui] && (m_tag[ui] == ut);
      mis  = branch_ex && ((m_ptex != branch_taken) || (m_ptex && (m_ptgtex != jump_pc)));
      if (!if_stall) begin
        m_lk_v   = if_valid;
        m_lk_t   = if_valid && lhit && m_cnt[li][1];
        m_lk_tgt = (if_valid && lhit) ? m_tgt[li] : 32'd0;
      end
      m_fl = mis;
      if (mis) m_npc = branch_taken ? jump_pc : njump_pc;
      if (branch_ex) begin
        m_sb = m_sb + 32'd1;
        if (mis) m_sm = m_sm + 32'd1;
        if (branch_taken) begin
          if (uhit) begin
            if (m_cnt[ui] != 2'd3) m_cnt[ui] = m_cnt[ui] + 2'd1;
          end else begin
            m_valid[ui] = 1'b1;
            m_tag[ui]   = ut;
            m_cnt[ui]   = 2'd2;
          end
          m_tgt[ui] = jump_pc;
        end else if (uhit && (m_cnt[ui] != 2'd0)) begin
          m_cnt[ui] = m_cnt[ui] - 2'd1;
        end
      end
      if (new_request_dec) begin
        m_ptex   = pred_taken_dec;
        m_ptgtex = pred_target_dec;
      end
    end
    e.pv  = m_lk_v && !m_fl;
    e.pt  = m_lk_t;
    e.tgt = m_lk_tgt;
    e.fl  = m_fl;
    e.npc = m_npc;
    e.sb  = m_sb;
    e.sm  = m_sm;
  endtask

  // One clock: push the expectation, then compare once the edge has passed
  task automatic step();
    exp_t e;
    model_eval(e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_val("sb_pred_valid", 32'(if_pred_valid), 32'(e.pv));
    check_val("sb_flush", 32'(flush), 32'(e.fl));
    check_val("sb_new_pc", new_pc, e.npc);
    if (e.pv) begin
      check_val("sb_pred_taken", 32'(if_pred_taken), 32'(e.pt));
      check_val("sb_pred_target", if_pred_target, e.tgt);
    end
`ifdef BRANCH_PREDICTOR_STATS_EN
    check_val("sb_stat_br", stat_branches, e.sb);
    check_val("sb_stat_mp", stat_mispredicts, e.sm);
`endif
  endtask

  task automatic lookup(input logic [31:0] pc);
    if_valid = 1'b1;
    if_pc    = pc;
    step();
    if_valid = 1'b0;
  endtask

  // Send the prediction down from decode, then resolve it in execute
  task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] jpc,
                         input logic pt, input logic [31:0] ptgt);
    new_request_dec = 1'b1;
    pred_taken_dec  = pt;
    pred_target_dec = ptgt;
    step();
    new_request_dec = 1'b0;
    branch_ex    = 1'b1;
    ex_pc        = pc;
    branch_taken = tk;
    jump_pc      = jpc;
    njump_pc     = pc + 32'd4;
    step();
    branch_ex = 1'b0;
  endtask

  task automatic expect_lookup(input string tag, input logic pt, input logic [31:0] tgt);
    check_val({tag, "_valid"}, 32'(if_pred_valid), 32'd1);
    check_val({tag, "_taken"}, 32'(if_pred_taken), 32'(pt));
    check_val({tag, "_target"}, if_pred_target, tgt);
  endtask

  task automatic expect_flush(input string tag, input logic [31:0] npc);
    check_val({tag, "_flush"}, 32'(flush), 32'd1);
    check_val({tag, "_new_pc"}, new_pc, npc);
  endtask

  initial begin
    rst = 1'b1;
    if_pc = 32'd0; if_valid = 1'b0; if_stall = 1'b0;
    new_request_dec = 1'b0; pred_taken_dec = 1'b0; pred_target_dec = 32'd0;
    branch_ex = 1'b0; ex_pc = 32'd0; branch_taken = 1'b0;
    jump_pc = 32'd0; njump_pc = 32'd0;
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = 8'd0; m_cnt[i] = 2'd0; m_tgt[i] = 32'd0;
    end

    step();
    step();
    check_val("rst_pred_valid", 32'(if_pred_valid), 32'd0);
    check_val("rst_pred_taken", 32'(if_pred_taken), 32'd0);
    check_val("rst_pred_target", if_pred_target, 32'd0);
    check_val("rst_flush", 32'(flush), 32'd0);
    check_val("rst_new_pc", new_pc, 32'd0);
    rst = 1'b0;

    // Cold start, taken branch allocates at weakly taken
    lookup(32'h100);
    expect_lookup("t1_cold", 1'b0, 32'd0);
    resolve(32'h100, 1'b1, 32'h200, 1'b0, 32'd0);
    expect_flush("t1", 32'h200);
    lookup(32'h100);
    expect_lookup("t1_hit", 1'b1, 32'h200);
    check_val("t1_flush_clear", 32'(flush), 32'd0);

    // Saturate at 3; one not-taken keeps taken, second flips to not-taken
    for (int i = 0; i < 3; i++) begin
      resolve(32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
      check_val("t2_no_flush", 32'(flush), 32'd0);
    end
    resolve(32'h100, 1'b0, 32'h200, 1'b1, 32'h200);
    expect_flush("t2_nt1", 32'h104);
    lookup(32'h100);
    expect_lookup("t2_cnt2", 1'b1, 32'h200);
    resolve(32'h100, 1'b0, 32'h200, 1'b1, 32'h200);
    lookup(32'h100);
    expect_lookup("t2_cnt1", 1'b0, 32'h200);

    // Wrong target redirects and retrains the target
    resolve(32'h100, 1'b1, 32'h300, 1'b1, 32'h200);
    expect_flush("t3", 32'h300);
    lookup(32'h100);
    expect_lookup("t3_hit", 1'b1, 32'h300);

    // Not-taken miss redirects to fall-through without allocating
    resolve(32'h400, 1'b0, 32'h900, 1'b1, 32'h500);
    expect_flush("t4", 32'h404);
    lookup(32'h400);
    expect_lookup("t4_miss", 1'b0, 32'd0);

    // Alias at index 0 with same-cycle lookup of the old owner
    new_request_dec = 1'b1; pred_taken_dec = 1'b1; pred_target_dec = 32'h500;
    step();
    new_request_dec = 1'b0;
    branch_ex = 1'b1; ex_pc = 32'h4100; branch_taken = 1'b1;
    jump_pc = 32'h500; njump_pc = 32'h4104;
    if_valid = 1'b1; if_pc = 32'h100;
    step();
    branch_ex = 1'b0; if_valid = 1'b0;
    expect_lookup("t5_old", 1'b1, 32'h300);
    check_val("t5_no_flush", 32'(flush), 32'd0);
    lookup(32'h100);
    expect_lookup("t5_evicted", 1'b0, 32'd0);
    lookup(32'h4100);
    expect_lookup("t5_new", 1'b1, 32'h500);

    // Redirect masks valid, while the lookup itself is still captured
    branch_ex = 1'b1; ex_pc = 32'h800; branch_taken = 1'b0; njump_pc = 32'h804;
    if_valid = 1'b1; if_pc = 32'h4100;
    step();
    check_val("t5_mask_valid", 32'(if_pred_valid), 32'd0);
    expect_flush("t5_mask", 32'h804);
    branch_ex = 1'b0; if_valid = 1'b0; if_stall = 1'b1;
    step();
    expect_lookup("t5_unmask", 1'b1, 32'h500);
    if_stall = 1'b0;

    // Back-to-back resolutions give back-to-back flushes
    branch_ex = 1'b1;
    step();
    expect_flush("b2b_1", 32'h804);
    step();
    expect_flush("b2b_2", 32'h804);
    branch_ex = 1'b0;

    // Stall holds lookup outputs while the PC moves
    lookup(32'h4100);
    expect_lookup("t6_pre", 1'b1, 32'h500);
    if_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if_valid = i[0];
      if_pc    = 32'h400 * 32'(i);
      step();
      expect_lookup("t6_stall", 1'b1, 32'h500);
    end
    if_stall = 1'b0; if_valid = 1'b0;

    // Reset drops a pending flush and invalidates the table
    branch_ex = 1'b1;
    step();
    expect_flush("t6_pend", 32'h804);
    rst = 1'b1;
    step();
    check_val("t6_rst_flush", 32'(flush), 32'd0);
    check_val("t6_rst_new_pc", new_pc, 32'd0);
    rst = 1'b0; branch_ex = 1'b0;
    lookup(32'h100);
    expect_lookup("t6_miss_a", 1'b0, 32'd0);
    lookup(32'h4100);
    expect_lookup("t6_miss_b", 1'b0, 32'd0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
